// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one shared full-adder cell, LSB first, one bit per clock.
// Optional macro SERIAL_ADD_SUB_EN adds a `sub` port for two's-complement subtraction.

module fa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));

endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shA_q, shA_d;
  logic [WIDTH-1:0] shB_q, shB_d;
  logic [WIDTH-2:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;

  logic             faSum, faCarry;
  logic [WIDTH-1:0] accShift;
  logic             lastBit;
  logic [WIDTH-1:0] loadB;
  logic             loadCarry;

  fa uFa (
    .a     (shA_q[0]),
    .b     (shB_q[0]),
    .c     (carry_q),
    .sum   (faSum),
    .carry (faCarry)
  );

  // acc keeps only the WIDTH-1 sum bits collected so far; the new bit enters at the top.
  assign accShift = {faSum, acc_q};
  assign lastBit  = (cnt_q == CntW'(WIDTH - 1));

  always_comb begin
    loadB     = op_b;
    loadCarry = cin;
`ifdef SERIAL_ADD_SUB_EN
    if (sub) begin
      loadB     = ~op_b;
      loadCarry = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    shA_d    = shA_q;
    shB_d    = shB_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    cout_d   = cout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          shA_d   = op_a;
          shB_d   = loadB;
          carry_d = loadCarry;
          cnt_d   = '0;
          acc_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        shA_d   = {1'b0, shA_q[WIDTH-1:1]};
        shB_d   = {1'b0, shB_q[WIDTH-1:1]};
        acc_d   = accShift[WIDTH-1:1];
        carry_d = faCarry;
        cnt_d   = cnt_q + CntW'(1);
        if (lastBit) begin
          result_d = accShift;
          cout_d   = faCarry;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shA_q    <= '0;
      shB_q    <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shA_q    <= shA_d;
      shB_q    <= shB_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: an 8-bit and a 4-bit instance checked every cycle against
// a transaction-level arithmetic model, plus directed literal expectations.

module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, cin8, sub8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8;
  logic [7:0] result8;
  logic       start4, cin4, sub4;
  logic [3:0] a4, b4;
  logic       busy4, done4, cout4;
  logic [3:0] result4;

  int checks = 0;
  int errors = 0;
  logic checkEn = 1'b0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub8),
`endif
    .op_a(a8), .op_b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .result(result8), .cout(cout8)
  );

  serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub4),
`endif
    .op_a(a4), .op_b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .result(result4), .cout(cout4)
  );

  // Expected {cout, result} of one operation as plain arithmetic.
  function automatic logic [32:0] expVal(input int w, input logic [31:0] a, input logic [31:0] b,
                                         input logic c, input logic s);
    logic [32:0] mask;
    logic [32:0] bb;
    mask = (33'd1 << w) - 33'd1;
    bb   = s ? ({1'b0, ~b} & mask) : {1'b0, b};
    return {1'b0, a} + bb + (s ? 33'd1 : {32'b0, c});
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level model: an accepted request completes WIDTH edges later.
  logic        mBusy[2] = '{1'b0, 1'b0};
  logic        mDone[2] = '{1'b0, 1'b0};
  logic        mCout[2] = '{1'b0, 1'b0};
  logic [31:0] mRes[2]  = '{32'd0, 32'd0};
  logic [32:0] mPend[2] = '{33'd0, 33'd0};
  int          mLeft[2] = '{0, 0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mBusy[i] = 1'b0; mDone[i] = 1'b0; mCout[i] = 1'b0;
        mRes[i] = '0; mPend[i] = '0; mLeft[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int w;
        w = (i == 0) ? 8 : 4;
        mDone[i] = 1'b0;
        if (mBusy[i]) begin
          mLeft[i]--;
          if (mLeft[i] == 0) begin
            mBusy[i] = 1'b0;
            mDone[i] = 1'b1;
            mRes[i]  = mPend[i][31:0] & ((32'd1 << w) - 32'd1);
            mCout[i] = mPend[i][w];
          end
        end else if ((i == 0) ? start8 : start4) begin
          mBusy[i] = 1'b1;
          mLeft[i] = w;
          mPend[i] = (i == 0) ? expVal(8, {24'b0, a8}, {24'b0, b8}, cin8, sub8)
                              : expVal(4, {28'b0, a4}, {28'b0, b4}, cin4, sub4);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("busy8", {31'b0, busy8}, {31'b0, mBusy[0]});
      checkOutput("done8", {31'b0, done8}, {31'b0, mDone[0]});
      checkOutput("result8", {24'b0, result8}, mRes[0]);
      checkOutput("cout8", {31'b0, cout8}, {31'b0, mCout[0]});
      checkOutput("busy4", {31'b0, busy4}, {31'b0, mBusy[1]});
      checkOutput("done4", {31'b0, done4}, {31'b0, mDone[1]});
      checkOutput("result4", {28'b0, result4}, mRes[1]);
      checkOutput("cout4", {31'b0, cout4}, {31'b0, mCout[1]});
    end
  end

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
    a8 = a; b8 = b; cin8 = c; sub8 = s; start8 = 1'b1;
  endtask

  // Waits for done8 after a start already driven; optionally pulses a second start at cycle pulseAt.
  task automatic waitDone8(input string name, input int pulseAt, input logic [7:0] expRes,
                           input logic expCout);
    int n = 0;
    int busyN = 0;
    while (n < 40) begin
      @(negedge clk); #1;
      n++;
      if (busy8) busyN++;
      if (done8) break;
      start8 = (n == pulseAt);
      if (n == pulseAt) begin
        a8 = 8'h70; b8 = 8'h70;
      end else if (n == 1) begin
        a8 = ~a8; b8 = ~b8; cin8 = ~cin8;
      end
    end
    start8 = 1'b0;
    checkOutput({name, "_latency"}, n - 1, 8);
    checkOutput({name, "_busycycles"}, busyN, 8);
    checkOutput({name, "_result"}, {24'b0, result8}, {24'b0, expRes});
    checkOutput({name, "_cout"}, {31'b0, cout8}, {31'b0, expCout});
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic c);
    int n = 0;
    a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
    while (n < 20) begin
      @(negedge clk); #1;
      n++;
      if (n == 1) start4 = 1'b0;
      if (done4) break;
    end
    checkOutput("exh4_latency", n - 1, 4);
    checkOutput("exh4_sum", {27'b0, cout4, result4}, {27'b0, 5'(a) + 5'(b) + 5'(c)});
  endtask

  initial begin
    int doneSeen;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", {31'b0, busy8}, 0);
    checkOutput("reset_done", {31'b0, done8}, 0);
    checkOutput("reset_result", {24'b0, result8}, 0);
    checkOutput("reset_cout", {31'b0, cout8}, 0);
    #1 rst_n = 1'b1;
    checkEn = 1'b1;

    applyStimulus(8'h5A, 8'h3C, 1'b0, 1'b0);
    waitDone8("basic", 0, 8'h96, 1'b0);
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0);
    waitDone8("wrap1", 0, 8'h00, 1'b1);
    applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b0);
    waitDone8("wrap2", 0, 8'hFF, 1'b1);

    applyStimulus(8'h01, 8'h02, 1'b0, 1'b0);
    waitDone8("busyprot", 3, 8'h03, 1'b0);
    applyStimulus(8'h10, 8'h20, 1'b0, 1'b0);
    waitDone8("backtoback", 0, 8'h30, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
    applyStimulus(8'h10, 8'h01, 1'b0, 1'b1);
    waitDone8("sub1", 0, 8'h0F, 1'b1);
    applyStimulus(8'h00, 8'h01, 1'b0, 1'b1);
    waitDone8("sub2", 0, 8'hFF, 1'b0);
    applyStimulus(8'h5A, 8'h3C, 1'b0, 1'b0);
    waitDone8("subzero", 0, 8'h96, 1'b0);
    sub8 = 1'b0;
`endif

    // Abort an operation mid-flight: outputs must clear at once and no done may follow.
    applyStimulus(8'h5A, 8'h3C, 1'b0, 1'b0);
    @(negedge clk); #1 start8 = 1'b0;
    repeat (3) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy", {31'b0, busy8}, 0);
    checkOutput("midreset_done", {31'b0, done8}, 0);
    checkOutput("midreset_result", {24'b0, result8}, 0);
    checkOutput("midreset_cout", {31'b0, cout8}, 0);
    @(negedge clk); #3 rst_n = 1'b1;
    doneSeen = 0;
    repeat (12) begin
      @(negedge clk); #1;
      if (done8) doneSeen++;
    end
    checkOutput("midreset_nodone", doneSeen, 0);

    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          run4(4'(a), 4'(b), c[0]);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
